spi_resp: RTL

SPI responder (slave) for the BMP280 command protocol, clocked from the 12 MHz system clock. It oversamples `sck`/`csb`/`sdi` and decodes control bytes (R/W bit + 7-bit address) into single-cycle register-bus strobes. It serialises read data on `sdo`. It is the counterpart of the SPI master, used as a BMP280 emulator in loopback and on-board tests.

---
 rtl/spi_resp.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/spi_resp.sv
// rtl/spi_resp.sv - SPI responder emulating the BMP280 control/data byte protocol
//
// Ports:
//   clk12MHz, rst          system clock, synchronous active-high reset
//   sck, csb, sdi          SPI pins from the master (asynchronous, modes 0 and 3)
//   sdo, sdo_oe            read data to the master and its output enable
//   reg_addr               register address, bit 7 always set
//   reg_wdata, reg_we      write data and one-cycle write strobe
//   reg_re, reg_rdata      one-cycle read strobe; read data valid one cycle later
//   busy                   a transaction is being decoded
module spi_resp #(
    parameter int RESET_SYNC_STAGES = 2
) (
    input  logic       clk12MHz,
    input  logic       rst,
    input  logic       sck,
    input  logic       csb,
    input  logic       sdi,
    output logic       sdo,
    output logic       sdo_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    localparam int N = RESET_SYNC_STAGES;

    typedef enum logic [1:0] {IDLE, CTRL, WDATA, RDATA} state_t;

    state_t state, state_next;

    logic [N-1:0] sck_sync, csb_sync, sdi_sync;
    logic         sck_d, csb_d;
    logic         sck_rise, sck_fall, csb_fall, csb_rise;
    logic [2:0]   bit_cnt;
    logic [7:0]   rx_shift, rx_byte, tx_shift;
    logic         byte_done;
    logic         re_d;
    logic         first_pair;

    // Synchroniser chains reset to 0 so that a csb already low when reset
    // releases never looks like a fresh falling edge.
    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            sck_sync <= '0;
            csb_sync <= '0;
            sdi_sync <= '0;
            sck_d    <= 1'b0;
            csb_d    <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[N-2:0], sck};
            csb_sync <= {csb_sync[N-2:0], csb};
            sdi_sync <= {sdi_sync[N-2:0], sdi};
            sck_d    <= sck_sync[N-1];
            csb_d    <= csb_sync[N-1];
        end
    end

    assign sck_rise  =  sck_sync[N-1] & ~sck_d;
    assign sck_fall  = ~sck_sync[N-1] &  sck_d;
    assign csb_fall  = ~csb_sync[N-1] &  csb_d;
    assign csb_rise  =  csb_sync[N-1] & ~csb_d;

    // sdi has the same synchroniser depth as sck, so it lines up with sck_rise.
    assign rx_byte   = {rx_shift[6:0], sdi_sync[N-1]};
    assign byte_done = sck_rise && (bit_cnt == 3'd7);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk12MHz) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (csb_rise) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (csb_fall) state_next = CTRL;
                CTRL:    if (byte_done) state_next = (rx_byte[7] && first_pair) ? RDATA : WDATA;
                WDATA:   if (byte_done) state_next = CTRL;
                RDATA:   state_next = RDATA;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            sdo        <= 1'b0;
            sdo_oe     <= 1'b0;
            reg_addr   <= 8'h80;
            reg_wdata  <= 8'h00;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            bit_cnt    <= 3'd0;
            rx_shift   <= 8'h00;
            tx_shift   <= 8'h00;
            re_d       <= 1'b0;
            first_pair <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            re_d   <= reg_re;
            if (csb_rise) begin
                // csb_rise outranks a coincident sck_rise: the partial byte is dropped.
                sdo_oe  <= 1'b0;
                bit_cnt <= 3'd0;
            end else if (state == IDLE) begin
                sdo_oe  <= 1'b0;
                bit_cnt <= 3'd0;
                if (csb_fall) first_pair <= 1'b1;
            end else begin
                if (sck_rise) begin
                    rx_shift <= rx_byte;
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    case (state)
                        CTRL: begin
                            reg_addr   <= {1'b1, rx_byte[6:0]};
                            first_pair <= 1'b0;
                            // Only the first control byte of a frame may start a read.
                            if (rx_byte[7] && first_pair) reg_re <= 1'b1;
                        end
                        WDATA: begin
                            reg_wdata <= rx_byte;
                            reg_we    <= 1'b1;
                        end
                        RDATA: begin
                            reg_addr <= {1'b1, reg_addr[6:0] + 7'd1};
                            reg_re   <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                // The first fall seen in RDATA is the last fall of the control
                // byte, which presents data bit 7.
                if (state == RDATA && sck_fall) begin
                    sdo      <= tx_shift[7];
                    sdo_oe   <= 1'b1;
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end
            // Loads land well before the next sck_fall given the minimum sck phase.
            if (re_d) tx_shift <= reg_rdata;
        end
    end

endmodule
